// File: rtl/bias_sequencer.sv
// bias_sequencer
// Sequences the external combinational bias_adder between the systolic array
// row stream and the output buffer. The block holds the per-tile bias vector
// and the float/integer mode, accepts num_rows array rows per tile over a
// valid/ready handshake, and presents each row together with the bias to
// bias_adder. Each biased result is registered into a one-entry output stage.
//
// Ports
//   clk          system clock
//   n_rst        synchronous reset, active-low
//   bias_load    pulse: capture bias_data (IDLE only)
//   bias_data    bias vector
//   start        pulse: begin a tile (IDLE only)
//   num_rows     rows in the tile, sampled with start
//   float_mode   adder mode for the tile, sampled with start
//   row_valid    array row available
//   row_data     array row
//   row_ready    row accepted when row_valid & row_ready
//   adder_in     to bias_adder.array_outputs (zero outside ACTIVE)
//   adder_bias   to bias_adder.bias
//   adder_float  to bias_adder.float
//   adder_result from bias_adder.bias_outputs
//   out_valid    biased row valid
//   out_data     biased row
//   out_ready    consumer accepts when out_valid & out_ready
//   busy         high in ACTIVE and DRAIN
//   tile_done    one-cycle pulse at tile end
//   err          one-cycle pulse on an illegal command
module bias_sequencer #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              bias_load,
  input  logic [DATA_W-1:0] bias_data,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_rows,
  input  logic              float_mode,
  input  logic              row_valid,
  input  logic [DATA_W-1:0] row_data,
  output logic              row_ready,
  output logic [DATA_W-1:0] adder_in,
  output logic [DATA_W-1:0] adder_bias,
  output logic              adder_float,
  input  logic [DATA_W-1:0] adder_result,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              tile_done,
  output logic              err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   bias_q, bias_d;
  logic                bias_valid_q, bias_valid_d;
  logic                mode_q, mode_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                tile_done_q, tile_done_d;
  logic                err_q, err_d;
  logic                row_ready_s;
  logic [DATA_W-1:0]   adder_in_s;

  // Next-state, datapath capture and handshake decode.
  always_comb begin
    state_d      = state_q;
    bias_d       = bias_q;
    bias_valid_d = bias_valid_q;
    mode_d       = mode_q;
    cnt_d        = cnt_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    err_d        = 1'b0;
    row_ready_s  = 1'b0;
    adder_in_s   = {DATA_W{1'b0}};

    case (state_q)
      ST_IDLE: begin
        if (bias_load) begin
          bias_d       = bias_data;
          bias_valid_d = 1'b1;
        end else begin
          bias_d       = bias_q;
        end
        if (start) begin
          // A bias loaded in the same cycle counts as present for this tile.
          if ((bias_valid_q || bias_load) && (num_rows != CNT_ZERO)) begin
            cnt_d   = num_rows;
            mode_d  = float_mode;
            state_d = ST_ACTIVE;
          end else begin
            err_d   = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ACTIVE: begin
        // One-entry output stage: a new row may enter whenever the stage
        // is empty or is being emptied this cycle.
        row_ready_s = !out_valid_q || out_ready;
        adder_in_s  = row_data;
        err_d       = bias_load || start;
        if (row_valid && row_ready_s) begin
          out_valid_d = 1'b1;
          out_data_d  = adder_result;
          cnt_d       = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_ACTIVE;
          end
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
        end else begin
          out_valid_d = out_valid_q;
        end
      end

      ST_DRAIN: begin
        err_d = bias_load || start;
        if (!out_valid_q) begin
          state_d = ST_DONE;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_DONE;
        end else begin
          state_d     = ST_DRAIN;
        end
      end

      ST_DONE: begin
        err_d   = bias_load || start;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // tile_done is registered, so it is high exactly while the FSM sits in DONE.
    tile_done_d = (state_d == ST_DONE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q      <= ST_IDLE;
      bias_q       <= {DATA_W{1'b0}};
      bias_valid_q <= 1'b0;
      mode_q       <= 1'b0;
      cnt_q        <= CNT_ZERO;
      out_valid_q  <= 1'b0;
      out_data_q   <= {DATA_W{1'b0}};
      tile_done_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      bias_q       <= bias_d;
      bias_valid_q <= bias_valid_d;
      mode_q       <= mode_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      tile_done_q  <= tile_done_d;
      err_q        <= err_d;
    end
  end

  assign row_ready   = row_ready_s;
  assign adder_in    = adder_in_s;
  assign adder_bias  = bias_q;
  assign adder_float = mode_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign busy        = (state_q == ST_ACTIVE) || (state_q == ST_DRAIN);
  assign tile_done   = tile_done_q;
  assign err         = err_q;

endmodule
